// File: rtl/ram_responder_if.sv
// MOV/MOC handshake bundle between the CPU's MAR/MDR path and the memory responder.
interface ram_responder_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  MOV;
    logic                  RW;
    logic [1:0]            Size;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           DataIn;
    logic [31:0]           DataOut;
    logic                  MOC;
    logic                  ERR;

    modport master (
        output MOV, RW, Size, Address, DataIn,
        input  DataOut, MOC, ERR
    );

    modport slave (
        input  MOV, RW, Size, Address, DataIn,
        output DataOut, MOC, ERR
    );
endinterface

// File: rtl/ram_responder.sv
// Big-endian byte-array memory answering MOV with MOC after WAIT_CYCLES wait states;
// rejects misaligned or reserved-size requests with ERR.
module ram_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          Clk,
    input  logic          Clear,
    ram_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  rw_q;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           din_q;

    logic [7:0]            Mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    logic                  req_err;
    logic [31:0]           rd_data;
    logic                  commit;

    // Byte lanes wrap modulo depth; aligned accesses never reach the wrap.
    assign a1 = addr_q + ADDR_WIDTH'(1);
    assign a2 = addr_q + ADDR_WIDTH'(2);
    assign a3 = addr_q + ADDR_WIDTH'(3);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        req_err = 1'b0;
        rd_data = '0;
        case (size_q)
            2'b00: rd_data = {24'h0, Mem[addr_q]};
            2'b01: begin
                req_err = addr_q[0];
                rd_data = {16'h0, Mem[addr_q], Mem[a1]};
            end
            2'b10: begin
                req_err = |addr_q[1:0];
                rd_data = {Mem[addr_q], Mem[a1], Mem[a2], Mem[a3]};
            end
            default: req_err = 1'b1;
        endcase
    end

    // A write commits only on the completion edge, and never on an edge where Clear wins.
    assign commit = (state == WAIT) && (cnt == 4'd0) && !rw_q && !req_err && !Clear;

    // NOTE: the memory has no reset so preloaded contents survive Clear.
    always_ff @(posedge Clk) begin
        if (commit) begin
            case (size_q)
                2'b00: Mem[addr_q] <= din_q[7:0];
                2'b01: begin
                    Mem[addr_q] <= din_q[15:8];
                    Mem[a1]     <= din_q[7:0];
                end
                2'b10: begin
                    Mem[addr_q] <= din_q[31:24];
                    Mem[a1]     <= din_q[23:16];
                    Mem[a2]     <= din_q[15:8];
                    Mem[a3]     <= din_q[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            bus.MOC     <= 1'b0;
            bus.ERR     <= 1'b0;
            bus.DataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MOV) begin
                        rw_q   <= bus.RW;
                        size_q <= bus.Size;
                        addr_q <= bus.Address;
                        din_q  <= bus.DataIn;
                        cnt    <= 4'(WAIT_CYCLES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.MOC <= 1'b1;
                        bus.ERR <= req_err;
                        if (rw_q) bus.DataOut <= req_err ? 32'h0 : rd_data;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.MOV) begin
                        bus.MOC <= 1'b0;
                        bus.ERR <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a driver queues expected responses, a monitor checks
// each MOC rising edge against the queue.
module tb_ram_responder;
    localparam int AW   = 9;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_pass   = 0;

    string       q_name[$];
    logic [31:0] q_data[$];
    logic        q_err[$];
    logic        moc_q = 1'b0;

    ram_responder_if #(.ADDR_WIDTH(AW)) bus ();

    ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT)) dut (
        .Clk  (clk),
        .Clear(clear),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every rising MOC must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.MOC && !moc_q) begin
            if (q_data.size() == 0) begin
                check("unexpected_moc", 32'(bus.MOC), 32'h0);
            end else begin
                string       nm;
                logic [31:0] d;
                logic        e;
                nm = q_name.pop_front();
                d  = q_data.pop_front();
                e  = q_err.pop_front();
                check({nm, "_data"}, bus.DataOut, d);
                check({nm, "_err"}, 32'(bus.ERR), 32'(e));
            end
        end
        moc_q = bus.MOC;
    end

    task automatic do_op(input string name, input logic rw, input logic [1:0] size,
                         input logic [AW-1:0] addr, input logic [31:0] din,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int hold, input bit drop_early);
        int k;
        bit held;
        @(negedge clk);
        bus.RW = rw; bus.Size = size; bus.Address = addr; bus.DataIn = din; bus.MOV = 1'b1;
        q_name.push_back(name); q_data.push_back(exp_data); q_err.push_back(exp_err);
        @(posedge clk); #1;
        // Scramble inputs after capture; the DUT must use its latched copies.
        bus.RW = ~rw; bus.Size = ~size; bus.Address = ~addr; bus.DataIn = ~din;
        if (drop_early) bus.MOV = 1'b0;
        k = 0;
        while (!bus.MOC && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_latency"}, 32'(k), 32'(WAIT + 1));
        if (drop_early) begin
            @(posedge clk); #1;
            check({name, "_pulse"}, 32'(bus.MOC), 32'h0);
        end else begin
            held = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!bus.MOC) held = 1'b0;
            end
            if (hold > 0) check({name, "_moc_held"}, 32'(held), 32'h1);
            @(negedge clk);
            bus.MOV = 1'b0;
            @(posedge clk); #1;
            check({name, "_moc_fall"}, {30'h0, bus.MOC, bus.ERR}, 32'h0);
        end
    endtask

    initial begin
        bit moc_seen;
        clear = 1'b1;
        bus.MOV = 1'b0; bus.RW = 1'b0; bus.Size = 2'b00; bus.Address = '0; bus.DataIn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("reset_moc", 32'(bus.MOC), 32'h0);
        check("reset_err", 32'(bus.ERR), 32'h0);
        check("reset_dataout", bus.DataOut, 32'h0);

        for (int i = 0; i < 2 ** AW; i++) dut.Mem[i] = 8'(i) ^ 8'h5A;
        dut.Mem[0] = 8'h8C; dut.Mem[1] = 8'h22; dut.Mem[2] = 8'h00; dut.Mem[3] = 8'h04;

        do_op("rd_word0", 1'b1, 2'b10, 9'd0, 32'h0, 32'h8C220004, 1'b0, 0, 1'b0);
        do_op("wr_word8", 1'b0, 2'b10, 9'd8, 32'hDEADBEEF, 32'h8C220004, 1'b0, 0, 1'b0);
        check("mem8_11", {dut.Mem[8], dut.Mem[9], dut.Mem[10], dut.Mem[11]}, 32'hDEADBEEF);
        do_op("rd_byte9", 1'b1, 2'b00, 9'd9, 32'h0, 32'h000000AD, 1'b0, 0, 1'b0);
        do_op("wr_half6", 1'b0, 2'b01, 9'd6, 32'hFFFF1234, 32'h000000AD, 1'b0, 0, 1'b0);
        do_op("rd_half6", 1'b1, 2'b01, 9'd6, 32'h0, 32'h00001234, 1'b0, 0, 1'b0);
        check("mem5_8_neighbours", {16'h0, dut.Mem[5], dut.Mem[8]}, 32'h00005FDE);

        do_op("rd_word2_misal", 1'b1, 2'b10, 9'd2, 32'h0, 32'h0, 1'b1, 0, 1'b0);
        do_op("wr_size11", 1'b0, 2'b11, 9'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 0, 1'b0);
        check("mem0_after_err", 32'(dut.Mem[0]), 32'h8C);
        do_op("rd_word0_hold", 1'b1, 2'b10, 9'd0, 32'h0, 32'h8C220004, 1'b0, 5, 1'b0);
        do_op("rd_half1_misal", 1'b1, 2'b01, 9'd1, 32'h0, 32'h0, 1'b1, 0, 1'b0);

        do_op("wr_byte_top", 1'b0, 2'b00, 9'h1FF, 32'hAAAAAA77, 32'h0, 1'b0, 0, 1'b0);
        do_op("rd_byte_top", 1'b1, 2'b00, 9'h1FF, 32'h0, 32'h00000077, 1'b0, 0, 1'b0);
        do_op("rd_half_top", 1'b1, 2'b01, 9'h1FE, 32'h0, 32'h0000A477, 1'b0, 0, 1'b0);
        do_op("rd_byte8_drop", 1'b1, 2'b00, 9'd8, 32'h0, 32'h000000DE, 1'b0, 0, 1'b1);

        // Abort a word write with Clear while the access is still waiting.
        @(negedge clk);
        bus.RW = 1'b0; bus.Size = 2'b10; bus.Address = 9'd16; bus.DataIn = 32'hCAFEBABE;
        bus.MOV = 1'b1;
        @(posedge clk); #1;
        bus.MOV = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        moc_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.MOC) moc_seen = 1'b1;
        end
        check("abort_no_moc", 32'(moc_seen), 32'h0);
        check("abort_mem16", {dut.Mem[16], dut.Mem[17], dut.Mem[18], dut.Mem[19]}, 32'h4A4B4849);
        check("abort_outputs", {bus.DataOut[29:0], bus.ERR, bus.MOC}, 32'h0);
        check("abort_dataout_hi", {30'h0, bus.DataOut[31:30]}, 32'h0);
        do_op("rd_word16", 1'b1, 2'b10, 9'd16, 32'h0, 32'h4A4B4849, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(q_data.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
